bus_arbiter_rr: RTL and testbench

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

---
 rtl/bus_arb_pkg.sv | 24 ++
 rtl/bus_arbiter_rr_if.sv | 46 ++++
 rtl/rr_priority_sel.sv | 30 +++
 rtl/bus_arbiter_rr.sv | 138 +++++++++++++
 tb/tb_bus_arbiter_rr.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
package bus_arb_pkg;

    // Arbiter FSM encoding.
    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StGrant     = 3'd1,
        StWaitBegin = 3'd2,
        StActive    = 3'd3,
        StRelease   = 3'd4
    } arbState_e;

    localparam int unsigned DEFAULT_NUM_MASTERS   = 4;
    localparam int unsigned DEFAULT_BEGIN_TIMEOUT = 16;
    localparam int unsigned DEFAULT_WATCHDOG      = 1024;

    // Counter width: one bit more than needed so the larger limit itself is representable.
    function automatic int unsigned cntWidth(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Shared-bus arbitration signals between the requesting masters and the arbiter.
interface bus_arbiter_rr_if
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEFAULT_NUM_MASTERS
);

    localparam int unsigned IdxW = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] requestTransaction;
    logic [NUM_MASTERS-1:0] transactionGranted;
    logic                   beginTransactionIn;
    logic                   endTransactionIn;
    logic                   busErrorIn;
    logic                   busErrorOut;
    logic                   endTransactionOut;
    logic [IdxW-1:0]        busOwner;
    logic                   busBusy;

    // Arbiter side.
    modport slave (
        input  requestTransaction,
        input  beginTransactionIn,
        input  endTransactionIn,
        input  busErrorIn,
        output transactionGranted,
        output busErrorOut,
        output endTransactionOut,
        output busOwner,
        output busBusy
    );

    // Requester / bus-agent side.
    modport master (
        output requestTransaction,
        output beginTransactionIn,
        output endTransactionIn,
        output busErrorIn,
        input  transactionGranted,
        input  busErrorOut,
        input  endTransactionOut,
        input  busOwner,
        input  busBusy
    );

endinterface

// File: rtl/rr_priority_sel.sv
// Combinational round-robin picker: first set request at or after startPtr, wrapping.
module rr_priority_sel
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEFAULT_NUM_MASTERS,
    localparam int unsigned IdxW = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] request,
    input  logic [IdxW-1:0]        startPtr,
    output logic [IdxW-1:0]        winner,
    output logic                   valid
);

    logic [IdxW-1:0] idx;

    // Scan requests in rotated order; the first hit wins and later hits are ignored.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            idx = IdxW'((int'(startPtr) + i) % int'(NUM_MASTERS));
            if (!valid && request[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin shared-bus arbiter with begin timeout and transaction watchdog.
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS   = DEFAULT_NUM_MASTERS,
    parameter int unsigned BEGIN_TIMEOUT = DEFAULT_BEGIN_TIMEOUT,
    parameter int unsigned WATCHDOG      = DEFAULT_WATCHDOG
) (
    input logic             clock,
    input logic             reset,
    bus_arbiter_rr_if.slave bus
);

    localparam int unsigned IdxW = $clog2(NUM_MASTERS);
    localparam int unsigned CntW = cntWidth(BEGIN_TIMEOUT, WATCHDOG);

    localparam logic [IdxW-1:0] LastIdx    = IdxW'(NUM_MASTERS - 1);
    localparam logic [CntW-1:0] BeginLimit = CntW'(BEGIN_TIMEOUT);
    localparam logic [CntW-1:0] WatchLimit = CntW'(WATCHDOG);

    arbState_e       stateQ, stateD;
    logic [IdxW-1:0] ownerQ, ownerD;
    logic [IdxW-1:0] lastOwnerQ, lastOwnerD;
    logic [CntW-1:0] cntQ, cntD;
    logic [CntW-1:0] cntInc;
    logic [IdxW-1:0] startPtr;
    logic [IdxW-1:0] winner;
    logic            winnerValid;
    logic            watchdogHit;

    // Round-robin search begins one past the previous owner, wrapping at the top index.
    assign startPtr = (lastOwnerQ == LastIdx) ? '0 : lastOwnerQ + 1'b1;

    // Saturating increment so a stuck state can never wrap the counter back into range.
    assign cntInc = (cntQ == '1) ? cntQ : cntQ + 1'b1;

    // Counter holds cycles spent in ACTIVE; reaching the limit is itself the timeout cycle.
    assign watchdogHit = (stateQ == StActive) && (cntQ >= WatchLimit);

    rr_priority_sel #(
        .NUM_MASTERS(NUM_MASTERS)
    ) uSel (
        .request (bus.requestTransaction),
        .startPtr(startPtr),
        .winner  (winner),
        .valid   (winnerValid)
    );

    // State, owner, round-robin pointer and timeout counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ     <= StIdle;
            ownerQ     <= '0;
            lastOwnerQ <= LastIdx;
            cntQ       <= '0;
        end else begin
            stateQ     <= stateD;
            ownerQ     <= ownerD;
            lastOwnerQ <= lastOwnerD;
            cntQ       <= cntD;
        end
    end

    // Next-state logic; bus strobes are only looked at in WAIT_BEGIN and ACTIVE.
    always_comb begin
        stateD     = stateQ;
        ownerD     = ownerQ;
        lastOwnerD = lastOwnerQ;
        cntD       = cntQ;
        unique case (stateQ)
            StIdle: begin
                if (winnerValid) begin
                    stateD = StGrant;
                    ownerD = winner;
                    cntD   = '0;
                end
            end
            StGrant: begin
                // Counter then equals cycles elapsed since the grant cycle.
                stateD = StWaitBegin;
                cntD   = cntInc;
            end
            StWaitBegin: begin
                if (bus.beginTransactionIn) begin
                    stateD = StActive;
                    cntD   = '0;
                end else if (cntQ >= BeginLimit) begin
                    // Grant forfeited silently; no error strobe.
                    stateD = StRelease;
                end else begin
                    cntD = cntInc;
                end
            end
            StActive: begin
                // Timeout cycle wins over a late end so the generated strobes stay one clean pulse.
                if (watchdogHit) begin
                    stateD = StRelease;
                end else if (bus.endTransactionIn || bus.busErrorIn) begin
                    stateD = StRelease;
                end else begin
                    cntD = cntInc;
                end
            end
            StRelease: begin
                stateD     = StIdle;
                lastOwnerD = ownerQ;
                cntD       = '0;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // Outputs decode straight from registered state, so they cannot glitch on bus inputs.
    always_comb begin
        bus.transactionGranted = '0;
        if (stateQ == StGrant) begin
            bus.transactionGranted[ownerQ] = 1'b1;
        end
        bus.busOwner          = ownerQ;
        bus.busBusy           = (stateQ != StIdle);
        bus.busErrorOut       = watchdogHit;
        bus.endTransactionOut = watchdogHit;
    end

    // Only one grant may ever be visible.
    assert property (@(posedge clock) disable iff (!reset) $onehot0(bus.transactionGranted));

    // Arbiter-generated strobes always travel together.
    assert property (@(posedge clock) disable iff (!reset)
        bus.busErrorOut == bus.endTransactionOut);

    // Generated strobes never outlast a single cycle.
    assert property (@(posedge clock) disable iff (!reset)
        bus.busErrorOut |=> !bus.busErrorOut);

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed self-checking bench for the round-robin bus arbiter.
module tb_bus_arbiter_rr;

    localparam int unsigned NM = 4;

    logic clock;
    logic reset;
    int   errors;
    int   checks;
    int   cycleCount;

    bus_arbiter_rr_if #(.NUM_MASTERS(NM)) bus ();

    bus_arbiter_rr #(
        .NUM_MASTERS  (NM),
        .BEGIN_TIMEOUT(16),
        .WATCHDOG     (1024)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
        cycleCount++;
    endtask

    task automatic clearInputs();
        bus.requestTransaction = '0;
        bus.beginTransactionIn = 1'b0;
        bus.endTransactionIn   = 1'b0;
        bus.busErrorIn         = 1'b0;
    endtask

    task automatic applyReset();
        reset = 1'b0;
        clearInputs();
        step();
        step();
        reset = 1'b1;
    endtask

    // Bounded wait for any grant; returns the grant vector seen (0 if the bound expired).
    task automatic waitGrant(input int limit, output logic [NM-1:0] g, output int n);
        n = 0;
        while (bus.transactionGranted == '0 && n < limit) begin
            step();
            n++;
        end
        g = bus.transactionGranted;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clearInputs();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.transactionGranted, bus.busBusy, bus.busOwner, bus.busErrorOut,
             bus.endTransactionOut} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got grant=%b busy=%b owner=%0d err=%b end=%b, want all 0",
                     bus.transactionGranted, bus.busBusy, bus.busOwner, bus.busErrorOut,
                     bus.endTransactionOut);
        end
        step();
        step();
        reset = 1'b1;
        // Bus strobes in IDLE must do nothing.
        bus.beginTransactionIn = 1'b1;
        bus.endTransactionIn   = 1'b1;
        bus.busErrorIn         = 1'b1;
        step();
        checks++;
        if ({bus.transactionGranted, bus.busBusy, bus.busErrorOut, bus.endTransactionOut} !== '0)
        begin
            errors++;
            $display("FAIL idle_ignore: got grant=%b busy=%b err=%b end=%b, want all 0",
                     bus.transactionGranted, bus.busBusy, bus.busErrorOut, bus.endTransactionOut);
        end
        clearInputs();
        step();
    endtask

    task automatic test_single();
        bus.requestTransaction = 4'b0100;                       // cycle 0
        checks++;
        if (bus.transactionGranted !== 4'b0000) begin
            errors++;
            $display("FAIL single_c0_grant: got %b want 0000", bus.transactionGranted);
        end
        step();                                                 // cycle 1
        checks++;
        if (bus.transactionGranted !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant: got %b want 0100", bus.transactionGranted);
        end
        checks++;
        if (bus.busOwner !== 2'd2 || bus.busBusy !== 1'b1) begin
            errors++;
            $display("FAIL single_owner: got owner=%0d busy=%b want 2/1", bus.busOwner, bus.busBusy);
        end
        bus.requestTransaction = '0;
        step();                                                 // cycle 2
        checks++;
        if (bus.transactionGranted !== 4'b0000) begin
            errors++;
            $display("FAIL single_pulse_width: got %b want 0000", bus.transactionGranted);
        end
        step();                                                 // cycle 3
        bus.beginTransactionIn = 1'b1;
        step();                                                 // cycle 4
        bus.beginTransactionIn = 1'b0;
        repeat (4) step();                                      // cycle 8
        bus.endTransactionIn = 1'b1;
        step();                                                 // cycle 9
        bus.endTransactionIn = 1'b0;
        checks++;
        if (bus.busBusy !== 1'b1 || bus.busErrorOut !== 1'b0) begin
            errors++;
            $display("FAIL single_c9: got busy=%b err=%b want 1/0", bus.busBusy, bus.busErrorOut);
        end
        step();                                                 // cycle 10
        checks++;
        if (bus.busBusy !== 1'b0) begin
            errors++;
            $display("FAIL single_c10_busy: got %b want 0", bus.busBusy);
        end
    endtask

    task automatic test_fairness();
        logic [NM-1:0] order [5];
        logic [NM-1:0] g;
        int            n;
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        applyReset();
        bus.requestTransaction = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            waitGrant(8, g, n);
            checks++;
            if (g !== order[t]) begin
                errors++;
                $display("FAIL fairness_%0d: got %b want %b (waited %0d)", t, g, order[t], n);
            end
            step();
            bus.beginTransactionIn = 1'b1;
            step();
            bus.beginTransactionIn = 1'b0;
            bus.endTransactionIn   = 1'b1;
            step();
            bus.endTransactionIn = 1'b0;
        end
        bus.requestTransaction = '0;
        step();
    endtask

    task automatic test_begin_timeout();
        logic sawStrobe;
        logic dropped;
        sawStrobe = 1'b0;
        dropped   = 1'b0;
        bus.requestTransaction = 4'b0110;                       // cycle 0
        step();                                                 // cycle 1
        checks++;
        if (bus.transactionGranted !== 4'b0010) begin
            errors++;
            $display("FAIL tmo_grant1: got %b want 0010", bus.transactionGranted);
        end
        bus.requestTransaction = 4'b0100;
        for (int c = 2; c <= 18; c++) begin
            step();
            if (bus.busErrorOut || bus.endTransactionOut) sawStrobe = 1'b1;
            if (!bus.busBusy) dropped = 1'b1;
        end                                                     // cycle 18 = RELEASE
        checks++;
        if (sawStrobe !== 1'b0 || dropped !== 1'b0) begin
            errors++;
            $display("FAIL tmo_wait: got strobe=%b early_release=%b want 0/0", sawStrobe, dropped);
        end
        step();                                                 // cycle 19 = IDLE
        checks++;
        if (bus.busBusy !== 1'b0 || bus.transactionGranted !== 4'b0000) begin
            errors++;
            $display("FAIL tmo_idle: got busy=%b grant=%b want 0/0000",
                     bus.busBusy, bus.transactionGranted);
        end
        step();                                                 // cycle 20
        checks++;
        if (bus.transactionGranted !== 4'b0100) begin
            errors++;
            $display("FAIL tmo_next_grant: got %b want 0100", bus.transactionGranted);
        end
        bus.requestTransaction = '0;
        step();
        bus.beginTransactionIn = 1'b1;
        step();
        bus.beginTransactionIn = 1'b0;
        bus.endTransactionIn   = 1'b1;
        step();
        bus.endTransactionIn = 1'b0;
        step();
    endtask

    task automatic test_watchdog();
        logic early;
        early = 1'b0;
        bus.requestTransaction = 4'b0001;                       // cycle 0
        step();                                                 // cycle 1
        checks++;
        if (bus.transactionGranted !== 4'b0001) begin
            errors++;
            $display("FAIL wdog_grant: got %b want 0001", bus.transactionGranted);
        end
        bus.requestTransaction = '0;
        step();                                                 // cycle 2
        bus.beginTransactionIn = 1'b1;
        step();                                                 // cycle 3
        bus.beginTransactionIn = 1'b0;
        if (bus.busErrorOut || bus.endTransactionOut) early = 1'b1;
        for (int c = 4; c <= 1026; c++) begin
            step();
            if (bus.busErrorOut || bus.endTransactionOut || !bus.busBusy) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL wdog_early: got early strobe/release=%b want 0", early);
        end
        step();                                                 // cycle 1027
        checks++;
        if (bus.busErrorOut !== 1'b1 || bus.endTransactionOut !== 1'b1) begin
            errors++;
            $display("FAIL wdog_strobe: got err=%b end=%b want 1/1",
                     bus.busErrorOut, bus.endTransactionOut);
        end
        step();                                                 // cycle 1028 = RELEASE
        checks++;
        if (bus.busErrorOut !== 1'b0 || bus.endTransactionOut !== 1'b0 || bus.busBusy !== 1'b1)
        begin
            errors++;
            $display("FAIL wdog_release: got err=%b end=%b busy=%b want 0/0/1",
                     bus.busErrorOut, bus.endTransactionOut, bus.busBusy);
        end
        step();                                                 // cycle 1029 = IDLE
        checks++;
        if (bus.busBusy !== 1'b0) begin
            errors++;
            $display("FAIL wdog_idle: got busy=%b want 0", bus.busBusy);
        end
    endtask

    task automatic test_simultaneous();
        bus.requestTransaction = 4'b0010;                       // cycle 0
        step();                                                 // cycle 1
        checks++;
        if (bus.transactionGranted !== 4'b0010) begin
            errors++;
            $display("FAIL simul_grant: got %b want 0010", bus.transactionGranted);
        end
        bus.requestTransaction = '0;
        step();                                                 // cycle 2
        bus.beginTransactionIn = 1'b1;
        step();                                                 // cycle 3
        bus.beginTransactionIn = 1'b0;
        bus.endTransactionIn   = 1'b1;
        bus.busErrorIn         = 1'b1;
        step();                                                 // cycle 4 = RELEASE
        bus.endTransactionIn = 1'b0;
        bus.busErrorIn       = 1'b0;
        checks++;
        if (bus.busBusy !== 1'b1 || bus.busErrorOut !== 1'b0 || bus.endTransactionOut !== 1'b0)
        begin
            errors++;
            $display("FAIL simul_release: got busy=%b err=%b end=%b want 1/0/0",
                     bus.busBusy, bus.busErrorOut, bus.endTransactionOut);
        end
        step();                                                 // cycle 5 = IDLE
        checks++;
        if (bus.busBusy !== 1'b0 || bus.busErrorOut !== 1'b0) begin
            errors++;
            $display("FAIL simul_idle: got busy=%b err=%b want 0/0", bus.busBusy, bus.busErrorOut);
        end
        step();                                                 // cycle 6
        checks++;
        if (bus.busBusy !== 1'b0 || bus.transactionGranted !== 4'b0000) begin
            errors++;
            $display("FAIL simul_single: got busy=%b grant=%b want 0/0000",
                     bus.busBusy, bus.transactionGranted);
        end
    endtask

    task automatic test_back_to_back();
        logic [NM-1:0] order [3];
        logic [NM-1:0] g;
        int            n;
        int            prevGrant;
        order     = '{4'b0100, 4'b1000, 4'b0001};
        prevGrant = -100;
        bus.requestTransaction = 4'b1111;
        for (int t = 0; t < 3; t++) begin
            waitGrant(8, g, n);
            checks++;
            if (g !== order[t]) begin
                errors++;
                $display("FAIL b2b_order_%0d: got %b want %b", t, g, order[t]);
            end
            checks++;
            if (cycleCount - prevGrant < 4) begin
                errors++;
                $display("FAIL b2b_spacing_%0d: got %0d cycles want >= 4", t, cycleCount - prevGrant);
            end
            prevGrant = cycleCount;
            step();
            bus.beginTransactionIn = 1'b1;
            step();
            bus.beginTransactionIn = 1'b0;
            bus.endTransactionIn   = 1'b1;
            step();
            bus.endTransactionIn = 1'b0;
        end
        bus.requestTransaction = '0;
        step();
    endtask

    task automatic test_reset_active();
        logic [NM-1:0] g;
        int            n;
        bus.requestTransaction = 4'b1000;                       // cycle 0
        step();                                                 // cycle 1
        checks++;
        if (bus.transactionGranted !== 4'b1000) begin
            errors++;
            $display("FAIL rst_act_grant: got %b want 1000", bus.transactionGranted);
        end
        bus.requestTransaction = '0;
        step();
        bus.beginTransactionIn = 1'b1;
        step();                                                 // ACTIVE
        bus.beginTransactionIn = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.transactionGranted, bus.busBusy, bus.busOwner, bus.busErrorOut,
             bus.endTransactionOut} !== '0) begin
            errors++;
            $display("FAIL rst_act_async: got busy=%b owner=%0d, want all outputs 0",
                     bus.busBusy, bus.busOwner);
        end
        step();
        step();
        checks++;
        if ({bus.transactionGranted, bus.busBusy, bus.busOwner, bus.busErrorOut,
             bus.endTransactionOut} !== '0) begin
            errors++;
            $display("FAIL rst_act_hold: got busy=%b owner=%0d, want all outputs 0",
                     bus.busBusy, bus.busOwner);
        end
        reset = 1'b1;
        bus.requestTransaction = 4'b1111;
        checks++;
        if (bus.busErrorOut !== 1'b0 || bus.endTransactionOut !== 1'b0) begin
            errors++;
            $display("FAIL rst_exit_strobe: got err=%b end=%b want 0/0",
                     bus.busErrorOut, bus.endTransactionOut);
        end
        waitGrant(4, g, n);
        checks++;
        if (g !== 4'b0001 || n != 1) begin
            errors++;
            $display("FAIL rst_first_grant: got %b after %0d want 0001 after 1", g, n);
        end
        bus.requestTransaction = '0;
        repeat (20) step();
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        cycleCount = 0;
        test_reset();
        test_single();
        test_fairness();
        test_begin_timeout();
        test_watchdog();
        test_simultaneous();
        test_back_to_back();
        test_reset_active();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
